// File: rtl/complex_acc_dump.sv
// Integrate-and-dump for complex products: full-precision sum of ACC_LEN samples,
// round-half-up shift and saturate at dump, then a 2-entry valid/ready output FIFO.
module complex_acc_dump #(
    parameter int DATA_LEN = 8,
    parameter int ACC_LEN  = 16,
    parameter int SHIFT    = 4,
    parameter int OUT_LEN  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [2*DATA_LEN-1:0] in_re,
    input  logic signed [2*DATA_LEN-1:0] in_im,
    input  logic                       in_vld,
    input  logic                       sync,
    output logic signed [OUT_LEN-1:0]  out_re,
    output logic signed [OUT_LEN-1:0]  out_im,
    output logic                       out_vld,
    input  logic                       out_rdy,
    input  logic                       clr_flags,
    output logic                       sat_flag,
    output logic                       drop_flag
);
    localparam int IN_W  = 2 * DATA_LEN;
    localparam int CNT_W = $clog2(ACC_LEN);
    localparam int ACC_W = IN_W + CNT_W;
    localparam int HS    = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ACC_LEN - 1);
    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] HALF  = (SHIFT > 0) ? (ONE <<< HS) : '0;
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W + 2 - OUT_LEN){1'b0}}, {(OUT_LEN - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W + 2 - OUT_LEN){1'b1}}, {(OUT_LEN - 1){1'b0}}};

    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W:0] ext;
        ext = {s[ACC_W-1], s};
        return (ext + HALF) >>> SHIFT;
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W:0] r);
        return (r > MAX_V) || (r < MIN_V);
    endfunction

    function automatic logic signed [OUT_LEN-1:0] saturate(input logic signed [ACC_W:0] r);
        if (r > MAX_V)
            return MAX_V[OUT_LEN-1:0];
        else if (r < MIN_V)
            return MIN_V[OUT_LEN-1:0];
        else
            return r[OUT_LEN-1:0];
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] in_re_x, in_im_x, sum_re, sum_im;
    logic signed [ACC_W-1:0] dump_re_p0, dump_im_p0;
    logic                    vld_p0;

    assign in_re_x = {{(ACC_W - IN_W){in_re[IN_W-1]}}, in_re};
    assign in_im_x = {{(ACC_W - IN_W){in_im[IN_W-1]}}, in_im};
    assign sum_re  = acc_re + in_re_x;
    assign sum_im  = acc_im + in_im_x;

    // Stage 0: accumulate; the last sample of a frame loads the dump register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc_re <= '0;
            acc_im <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (in_vld) begin
                if (sync || cnt == '0) begin
                    acc_re <= in_re_x;
                    acc_im <= in_im_x;
                    cnt    <= CNT_W'(1);
                end else begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        vld_p0 <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end else if (sync) begin
                cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld && !sync && cnt == CNT_LAST) begin
            dump_re_p0 <= sum_re;
            dump_im_p0 <= sum_im;
        end
    end

    // Stage 1: round/saturate the dump register and push into the FIFO
    logic signed [ACC_W:0]     rnd_re_p1, rnd_im_p1;
    logic signed [OUT_LEN-1:0] res_re_p1, res_im_p1;
    logic                      sat_p1;

    assign rnd_re_p1 = round_shift(dump_re_p0);
    assign rnd_im_p1 = round_shift(dump_im_p0);
    assign res_re_p1 = saturate(rnd_re_p1);
    assign res_im_p1 = saturate(rnd_im_p1);
    assign sat_p1    = sat_hit(rnd_re_p1) || sat_hit(rnd_im_p1);

    logic signed [OUT_LEN-1:0] mem_re [2];
    logic signed [OUT_LEN-1:0] mem_im [2];
    logic                      wr_ptr, rd_ptr;
    logic [1:0]                count;
    logic                      full, pop, accept;

    assign full   = (count == 2'd2);
    assign pop    = out_vld && out_rdy;
    // A pop in the same cycle frees the slot even when full
    assign accept = vld_p0 && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            sat_flag  <= (vld_p0 && sat_p1) || (sat_flag && !clr_flags);
            drop_flag <= (vld_p0 && full && !pop) || (drop_flag && !clr_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[wr_ptr] <= res_re_p1;
            mem_im[wr_ptr] <= res_im_p1;
        end
    end

    // Stage 2: FIFO head drives the outputs
    assign out_vld = (count != 2'd0);
    assign out_re  = out_vld ? mem_re[rd_ptr] : '0;
    assign out_im  = out_vld ? mem_im[rd_ptr] : '0;

endmodule

// File: tb/tb_complex_acc_dump.sv
// Randomized scoreboard bench for complex_acc_dump; two instances (OUT_LEN 16 and 8)
// share stimulus and are checked against a frame-level reference model.
module tb_complex_acc_dump;
    localparam int DATA_LEN = 8;
    localparam int ACC_LEN  = 4;
    localparam int SHIFT    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [15:0] in_re, in_im;
    logic               in_vld, sync, out_rdy, clr_flags;
    logic signed [15:0] o16_re, o16_im;
    logic               o16_vld, s16, d16;
    logic signed [7:0]  o8_re, o8_im;
    logic               o8_vld, s8, d8;

    complex_acc_dump #(.DATA_LEN(DATA_LEN), .ACC_LEN(ACC_LEN), .SHIFT(SHIFT), .OUT_LEN(16)) dut16 (
        .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_vld(in_vld), .sync(sync),
        .out_re(o16_re), .out_im(o16_im), .out_vld(o16_vld), .out_rdy(out_rdy),
        .clr_flags(clr_flags), .sat_flag(s16), .drop_flag(d16));

    complex_acc_dump #(.DATA_LEN(DATA_LEN), .ACC_LEN(ACC_LEN), .SHIFT(SHIFT), .OUT_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_vld(in_vld), .sync(sync),
        .out_re(o8_re), .out_im(o8_im), .out_vld(o8_vld), .out_rdy(out_rdy),
        .clr_flags(clr_flags), .sat_flag(s8), .drop_flag(d8));

    typedef struct {
        int re;
        int im;
    } cplx_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    cplx_t sb16[$];
    cplx_t sb8[$];
    int    fr_re[$];
    int    fr_im[$];
    bit    pend_v = 0;
    int    pend_re, pend_im;
    int    occ = 0;
    bit    m_sat16 = 0, m_sat8 = 0, m_drop = 0;
    bit    live = 0;

    function automatic int rnd(input int s);
        int h;
        h = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
        return (s + h) >>> SHIFT;
    endfunction

    function automatic int sat(input int r, input int w);
        int mx, mn;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        return (r > mx) ? mx : ((r < mn) ? mn : r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: frames of ACC_LEN samples, result pushed one cycle after dump
    always @(posedge clk) begin : model
        bit pop, set16, set8, setd;
        int rr, ri, sr, si;
        if (rst) begin
            fr_re.delete();
            fr_im.delete();
            sb16.delete();
            sb8.delete();
            pend_v  = 0;
            occ     = 0;
            m_sat16 = 0;
            m_sat8  = 0;
            m_drop  = 0;
            live    = 1;
        end else begin
            pop   = (occ > 0) && out_rdy;
            set16 = 0;
            set8  = 0;
            setd  = 0;
            if (pend_v) begin
                rr = rnd(pend_re);
                ri = rnd(pend_im);
                set16 = (sat(rr, 16) != rr) || (sat(ri, 16) != ri);
                set8  = (sat(rr, 8) != rr) || (sat(ri, 8) != ri);
                if (occ < 2 || pop) begin
                    sb16.push_back('{sat(rr, 16), sat(ri, 16)});
                    sb8.push_back('{sat(rr, 8), sat(ri, 8)});
                    occ++;
                end else begin
                    setd = 1;
                end
            end
            if (pop)
                occ--;
            m_sat16 = set16 || (m_sat16 && !clr_flags);
            m_sat8  = set8 || (m_sat8 && !clr_flags);
            m_drop  = setd || (m_drop && !clr_flags);
            pend_v  = 0;
            if (in_vld) begin
                if (sync) begin
                    fr_re.delete();
                    fr_im.delete();
                end
                fr_re.push_back(int'(in_re));
                fr_im.push_back(int'(in_im));
                if (fr_re.size() == ACC_LEN) begin
                    sr = 0;
                    si = 0;
                    foreach (fr_re[k]) begin
                        sr += fr_re[k];
                        si += fr_im[k];
                    end
                    pend_re = sr;
                    pend_im = si;
                    pend_v  = 1;
                    fr_re.delete();
                    fr_im.delete();
                end
            end else if (sync) begin
                fr_re.delete();
                fr_im.delete();
            end
        end
    end

    // Monitor: status every cycle, data popped from the scoreboard on each handshake
    always @(negedge clk) begin : monitor
        cplx_t e;
        if (live && !rst) begin
            check("vld16", int'(o16_vld), int'(occ > 0));
            check("vld8", int'(o8_vld), int'(occ > 0));
            check("sat16", int'(s16), int'(m_sat16));
            check("sat8", int'(s8), int'(m_sat8));
            check("drop16", int'(d16), int'(m_drop));
            check("drop8", int'(d8), int'(m_drop));
            if (o16_vld && out_rdy) begin
                if (sb16.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out16 at %0t: got unexpected output (%0d,%0d) required none", $time, o16_re, o16_im);
                end else begin
                    e = sb16.pop_front();
                    check("re16", int'(o16_re), e.re);
                    check("im16", int'(o16_im), e.im);
                end
            end
            if (o8_vld && out_rdy) begin
                if (sb8.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out8 at %0t: got unexpected output (%0d,%0d) required none", $time, o8_re, o8_im);
                end else begin
                    e = sb8.pop_front();
                    check("re8", int'(o8_re), e.re);
                    check("im8", int'(o8_im), e.im);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im, input bit sy);
        in_vld = 1'b1;
        in_re  = 16'(re);
        in_im  = 16'(im);
        sync   = sy;
        step();
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        sync   = 1'b0;
        for (int i = 0; i < n; i++)
            step();
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; sync = 1'b0; in_re = '0; in_im = '0;
        out_rdy = 1'b1; clr_flags = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld", int'(o16_vld), 0);
        check("rst_re", int'(o16_re), 0);
        check("rst_im", int'(o16_im), 0);
        check("rst_sat", int'(s8), 0);
        check("rst_drop", int'(d16), 0);

        // T1: plain frame
        for (int i = 0; i < 4; i++) send(100, -100, 0);
        idle(4);
        // T2: rounding half up
        send(1, -1, 0); send(1, -1, 0); send(0, 0, 0); send(0, 0, 0);
        idle(4);
        // T3: saturation on the 8-bit instance, then clear
        for (int i = 0; i < 4; i++) send(32767, -32768, 0);
        idle(3);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        idle(2);
        // T4: FIFO full, third frame dropped, then drain
        out_rdy = 1'b0;
        for (int k = 1; k <= 3; k++)
            for (int i = 0; i < 4; i++) send(k, k, 0);
        idle(4);
        out_rdy = 1'b1;
        idle(6);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        // T5: sync restarts a frame
        send(50, 50, 0); send(50, 50, 0); send(10, 10, 1);
        for (int i = 0; i < 3; i++) send(10, 10, 0);
        idle(4);
        // T6: reset mid-frame
        for (int i = 0; i < 3; i++) send(4, 4, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(4, 4, 0);
        idle(4);
        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_vld    = ($urandom % 10) < 7;
            in_re     = 16'($urandom);
            in_im     = 16'($urandom);
            sync      = ($urandom % 30) == 0;
            out_rdy   = ($urandom % 10) < 6;
            clr_flags = ($urandom % 40) == 0;
            step();
        end
        clr_flags = 1'b0;
        out_rdy   = 1'b1;
        idle(10);
        check("sb16_empty", sb16.size(), 0);
        check("sb8_empty", sb8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
